// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- instruction fetch stage feeding decode.
//
// Holds the fetch PC and issues in-order word reads over a valid/ready
// request port. Returned words are buffered with their PCs in a small queue.
// The queue head is presented to decode as the full word, its PC and the
// pre-sliced op/funct3/funct7 fields. A redirect flushes the queue and marks
// every in-flight request as stale, so its response is dropped on arrival.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   imem_req_valid/ready/addr        fetch request (word aligned)
//   imem_rsp_valid/data              in-order response, never back-pressured
//   redirect_valid/pc                branch/jump target, one-cycle pulse
//   dec_valid/ready                  queue head handshake to decode
//   dec_instr/pc/op/funct3/funct7    queue head contents (zero when empty)
//
// Optional build macro IFU_PERF_CNT_EN adds perf_stall_cnt (decode ready
// but nothing to give it) and perf_flush_cnt (redirect pulses), both
// saturating 32-bit counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_op,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(QUEUE_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        out_q, out_d;     // requests accepted, response not yet seen
  cnt_t        kill_q, kill_d;   // in-flight responses still to be dropped
  cnt_t        cnt_q, cnt_d;     // instruction queue occupancy
  ptr_t        rd_q, rd_d, wr_q, wr_d;
  ptr_t        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [QUEUE_DEPTH-1:0][31:0] q_instr_q, q_pc_q;
  logic [QUEUE_DEPTH-1:0][31:0] tag_pc_q;  // PC of each in-flight request

  logic has_room, acc, rsp, drop, enq, deq;

  // Credit check uses registered counts only; a slot freed this cycle is
  // not reusable until next cycle.
  assign has_room = (int'(out_q) + int'(cnt_q)) < QUEUE_DEPTH;
  assign imem_req_valid = (state_q == RUN) && has_room;
  assign imem_req_addr  = imem_req_valid ? fetch_pc_q : '0;

  assign acc  = imem_req_valid & imem_req_ready;
  // Responses with nothing outstanding (e.g. issued before a reset) are ignored.
  assign rsp  = imem_rsp_valid & (out_q != '0);
  assign drop = rsp & (kill_q != '0);
  // A response coinciding with a redirect belongs to the old path.
  assign enq  = rsp & ~drop & ~redirect_valid;
  assign deq  = dec_valid & dec_ready;

  assign dec_valid  = (cnt_q != '0);
  assign dec_instr  = dec_valid ? q_instr_q[rd_q] : '0;
  assign dec_pc     = dec_valid ? q_pc_q[rd_q]    : '0;
  assign dec_op     = dec_instr[6:0];
  assign dec_funct3 = dec_instr[14:12];
  assign dec_funct7 = dec_instr[31:25];

  always_comb begin
    out_d      = out_q + cnt_t'(acc) - cnt_t'(rsp);
    kill_d     = kill_q - cnt_t'(drop);
    cnt_d      = cnt_q + cnt_t'(enq) - cnt_t'(deq);
    rd_d       = deq ? ptr_inc(rd_q) : rd_q;
    wr_d       = enq ? ptr_inc(wr_q) : wr_q;
    // Tags pop on every counted response, dropped or not, so they stay
    // aligned with the response stream across redirects.
    tag_rd_d   = rsp ? ptr_inc(tag_rd_q) : tag_rd_q;
    tag_wr_d   = acc ? ptr_inc(tag_wr_q) : tag_wr_q;
    fetch_pc_d = acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    state_d    = state_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   if (kill_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (redirect_valid) begin
      // Everything still outstanding after this cycle is stale, including
      // a request accepted in this very cycle.
      kill_d     = out_d;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
      state_d    = (out_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      kill_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      kill_q     <= kill_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Payload storage needs no reset: it is only visible behind dec_valid.
  always_ff @(posedge clk) begin
    if (acc) tag_pc_q[tag_wr_q] <= fetch_pc_q;
    if (enq) begin
      q_instr_q[wr_q] <= imem_rsp_data;
      q_pc_q[wr_q]    <= tag_pc_q[tag_rd_q];
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (dec_ready && !dec_valid && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid && (perf_flush_q != 32'hFFFF_FFFF))
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid, dec_ready = 1'b0;
  logic [31:0] dec_instr, dec_pc;
  logic [6:0]  dec_op, dec_funct7;
  logic [2:0]  dec_funct3;

  // second instance, RESET_PC at the top of the address space
  logic        w_req_valid, w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0, w_redirect = 1'b0, w_dec_ready = 1'b0;
  logic [31:0] w_rsp_data = '0, w_redirect_pc = '0;
  logic        w_dec_valid;
  logic [31:0] w_dec_instr, w_dec_pc;
  logic [6:0]  w_dec_op, w_dec_funct7;
  logic [2:0]  w_dec_funct3;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, w_perf_stall, w_perf_flush;
`endif

  instr_fetch_unit u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_op(dec_op),
    .dec_funct3(dec_funct3), .dec_funct7(dec_funct7)
`ifdef IFU_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QUEUE_DEPTH(2)) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .dec_valid(w_dec_valid), .dec_ready(w_dec_ready),
    .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .dec_op(w_dec_op),
    .dec_funct3(w_dec_funct3), .dec_funct7(w_dec_funct7)
`ifdef IFU_PERF_CNT_EN
    , .perf_stall_cnt(w_perf_stall), .perf_flush_cnt(w_perf_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] w_log[$];
  int          nchk = 0, nerr = 0;
  int          cyc = 0, lat = 1;
  logic [31:0] forbid_lo = '0, forbid_hi = '0;
  bit          stale_seen = 1'b0;
  exp_t        mon_e;

  // Memory image: 0x00500093 (addi x1,x0,5) at address 0, address mixed
  // into bits [31:7] elsewhere. For small addresses this keeps op=0x13,
  // funct7=0 and makes funct3 = addr[7:5].
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[24:0], 7'h00};
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.instr = memf(pc);
    e.op = 7'h13; e.f3 = pc[7:5]; e.f7 = 7'h00;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_sb_empty(input string name, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (sb.size() == 0) return;
    end
    nchk++; nerr++;
    $display("FAIL %s: timeout with %0d expected entries left, required 0", name, sb.size());
  endtask

  task automatic wait_acc(input string name, input int idx, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (acc_log.size() > idx) return;
      tick();
    end
    nchk++; nerr++;
    $display("FAIL %s: timeout, %0d requests seen, required more than %0d", name, acc_log.size(), idx);
  endtask

  // Memory: in-order, latency `lat` cycles, one response per cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(pend[0].addr);
        void'(pend.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + lat});
        acc_log.push_back(imem_req_addr);
      end
    end
  end

  always @(negedge clk)
    if (reset_n && w_req_valid && w_req_ready && w_log.size() < 2)
      w_log.push_back(w_req_addr);

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (dec_valid && dec_pc >= forbid_lo && dec_pc < forbid_hi) stale_seen = 1'b1;
      if (dec_valid && dec_ready) begin
        nchk++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL dec_unexpected: got pc=%h instr=%h, required no consumption", dec_pc, dec_instr);
        end else begin
          mon_e = sb.pop_front();
          if ({dec_pc, dec_instr, dec_op, dec_funct3, dec_funct7} !==
              {mon_e.pc, mon_e.instr, mon_e.op, mon_e.f3, mon_e.f7}) begin
            nerr++;
            $display("FAIL dec_entry: got pc=%h instr=%h op=%h f3=%h f7=%h, required pc=%h instr=%h op=%h f3=%h f7=%h",
                     dec_pc, dec_instr, dec_op, dec_funct3, dec_funct7,
                     mon_e.pc, mon_e.instr, mon_e.op, mon_e.f3, mon_e.f7);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n0, lat_seen;
    exp_t e0;

    // ---- reset and cold-start latency ----
    repeat (3) tick();
    chk("reset_outputs", |{imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
                           dec_op, dec_funct3, dec_funct7}, 0);
    dec_ready = 1'b1;
    e0.pc = 32'h0; e0.instr = 32'h0050_0093; e0.op = 7'h13; e0.f3 = 3'h0; e0.f7 = 7'h00;
    sb.push_back(e0);
    for (int a = 4; a <= 20; a += 4) push_exp(a);
    reset_n = 1'b1;
    chk("boot_outputs", |{imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc}, 0);
    lat_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (dec_valid) begin lat_seen = i; break; end
    end
    chk("first_dec_latency", lat_seen, 3);
    wait_sb_empty("stream_a", 50);
    dec_ready = 1'b0;

    // ---- decode stalled: credits stop fetching ----
    n0 = acc_log.size();
    repeat (6) tick();
    chk("stall_req_count_le2", (acc_log.size() - n0) <= 2, 1);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_queue_full", dec_valid, 1);
    for (int a = 24; a <= 44; a += 4) push_exp(a);
    dec_ready = 1'b1;
    wait_sb_empty("drain_b", 50);
    dec_ready = 1'b0;

    // ---- redirect with two stale requests in flight ----
    repeat (4) tick();
    lat = 10;
    push_exp(48); push_exp(52);
    dec_ready = 1'b1;
    wait_sb_empty("drain_c", 20);
    dec_ready = 1'b0;
    repeat (3) tick();
    chk("two_outstanding_idle", {imem_req_valid, dec_valid}, 0);
    idx = acc_log.size();
    forbid_lo = 32'h0; forbid_hi = 32'h100; stale_seen = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    lat = 1;
    for (int a = 32'h100; a <= 32'h10C; a += 4) push_exp(a);
    tick();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    wait_acc("redir_req", idx, 40);
    if (acc_log.size() > idx) chk("redir_first_addr", acc_log[idx], 32'h100);
    wait_sb_empty("stream_redir", 60);
    dec_ready = 1'b0;
    chk("redir_no_stale", stale_seen, 0);

    // ---- redirect coinciding with accept + response, after a reset ----
    reset_n = 1'b0;
    repeat (2) tick();
    lat = 1; dec_ready = 1'b1;
    forbid_lo = 32'h0; forbid_hi = 32'h200; stale_seen = 1'b0;
    for (int a = 32'h200; a <= 32'h20C; a += 4) push_exp(a);
    reset_n = 1'b1;
    tick();  // BOOT -> RUN
    tick();  // request 0x0 accepted this cycle
    chk("coinc_req_valid", imem_req_valid, 1);
    chk("coinc_req_addr", imem_req_addr, 32'h4);
    idx = acc_log.size() + 1;  // this cycle's accept of 0x4 is the stale one
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("coinc_queue_empty", dec_valid, 0);
    wait_acc("coinc_req", idx, 40);
    if (acc_log.size() > idx) chk("coinc_first_addr", acc_log[idx], 32'h200);
    wait_sb_empty("stream_coinc", 60);
    dec_ready = 1'b0;
    chk("coinc_no_stale", stale_seen, 0);

    // ---- RESET_PC at top of address space wraps ----
    chk("wrap_req_count", w_log.size() >= 2, 1);
    if (w_log.size() >= 2) begin
      chk("wrap_first_addr", w_log[0], 32'hFFFF_FFFC);
      chk("wrap_second_addr", w_log[1], 32'h0);
    end

`ifdef IFU_PERF_CNT_EN
    // ---- performance counters ----
    reset_n = 1'b0; imem_req_ready = 1'b0; dec_ready = 1'b0;
    repeat (2) tick();
    chk("perf_reset", {perf_stall_cnt, perf_flush_cnt}, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    dec_ready = 1'b1;
    repeat (5) tick();
    dec_ready = 1'b0;
    redirect_pc = 32'h40;
    redirect_valid = 1'b1; tick(); redirect_valid = 1'b0; tick();
    redirect_valid = 1'b1; tick(); redirect_valid = 1'b0; tick();
    chk("perf_stall_cnt", perf_stall_cnt, 5);
    chk("perf_flush_cnt", perf_flush_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the decoder/control unit. Holds the fetch PC and issues in-order word reads to instruction memory over a valid/ready request port. Buffers returned instructions in a small queue and presents the head entry to decode as the full instruction, its PC, and the pre-sliced op/funct3/funct7 fields. Branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QUEUE_DEPTH, 2, instruction queue entries; also the maximum of (outstanding requests + queued entries); legal values are 2 or more

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  synchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response valid; responses return in order, at least 1 cycle after acceptance, and are never back-pressured
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  branch/jump taken; one-cycle pulse
redirect_pc  input  32  new fetch target
dec_valid  output  1  queue head valid
dec_ready  input  1  decoder consumes head
dec_instr  output  32  head instruction (32'h0 when empty)
dec_pc  output  32  PC of head instruction (32'h0 when empty)
dec_op  output  7  dec_instr[6:0]
dec_funct3  output  3  dec_instr[14:12]
dec_funct7  output  7  dec_instr[31:25]

Behaviour:
- Reset (reset_n=0 at a clk edge): fetch_pc=RESET_PC; queue empty; outstanding=0; kill_cnt=0; state=BOOT. All outputs are 0 during and immediately after reset.
- FSM states and transitions:
  - BOOT: no request. Moves to RUN after one cycle.
  - RUN: imem_req_valid=1 when (outstanding + count) < QUEUE_DEPTH, using registered values only; there is no same-cycle credit return.
  - FLUSH: imem_req_valid=0 while kill_cnt>0. Moves to RUN in the cycle after kill_cnt reaches 0.
- Request accepted (valid & ready): outstanding+1 and fetch_pc += 4. The addition is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Response: if kill_cnt>0, the response is dropped and kill_cnt-1. Otherwise it is enqueued with its PC, taken from an internal in-order PC tag FIFO. In both cases outstanding-1.
- No bypass: a response becomes visible on dec_* in the cycle after imem_rsp_valid. Minimum latency from request acceptance to dec_valid is 2 cycles.
- Dequeue on dec_valid & dec_ready. Enqueue and dequeue in the same cycle are allowed when the queue is full.
- Redirect (redirect_valid=1) takes priority over every same-cycle event:
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Queue is flushed; a same-cycle dequeue has no effect.
  - kill_cnt = outstanding after this cycle's accept and response, i.e. a same-cycle accepted request counts as stale and a same-cycle response counts as consumed-and-dropped.
  - state = FLUSH if the new kill_cnt>0, else RUN.
- Redirect during FLUSH: kill_cnt is recomputed by the same rule; no double counting.
- Reset asserted mid-operation clears all state at that edge. In-flight memory responses arriving after reset are ignored because outstanding=0.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: adds two ports.
  - perf_stall_cnt (output, 32): counts cycles with dec_ready=1 and dec_valid=0.
  - perf_flush_cnt (output, 32): counts redirect pulses.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor its logic exists; behaviour is otherwise identical.

Test Plan:
- Reset, then 1-cycle-latency memory with imem_req_ready=1 and dec_ready=1 → requests to 0x0, 0x4, 0x8…; first dec_valid 3 cycles after reset release; dec_pc=0x0; dec_instr=0x00500093 gives dec_op=0x13, dec_funct3=0, dec_funct7=0.
- dec_ready=0 → at most 2 requests issued, then imem_req_valid=0. Release dec_ready → in-order drain and fetching resumes.
- Redirect to 0x103 with 2 outstanding → next request addr=0x100; both stale responses dropped; first dec_pc=0x100; no instruction from the old path ever has dec_valid=1.
- Redirect coinciding with an accepted request and a response → kill_cnt counts the new request; queue empty next cycle.
- RESET_PC=32'hFFFF_FFFC → second request addr=0x0.
- With IFU_PERF_CNT_EN defined, 5 starved cycles and 2 redirects → perf_stall_cnt=5, perf_flush_cnt=2.
